floo_axi_txn_limiter: RTL and testbench
=======================================

Name: floo_axi_txn_limiter

Overview:
Per-direction outstanding-transaction limiter with W-burst gating. It sits directly downstream of the ID-remapping meta buffer, between that buffer's AXI output and the endpoint or NI. It caps in-flight reads and writes so that the compressed ID space and the meta queues can never be oversubscribed by the endpoint. It also holds W data until the matching AW has been accepted, and exports occupancy and idle status.

Parameters:
MaxReadTxns, 8, max outstanding read bursts, including ATOPs that return an R response; must be >= 1.
MaxWriteTxns, 8, max outstanding write bursts, including all ATOPs; must be >= 1.
AtopSupport, 1'b1, count ATOPs with R response in the read counter as well.
axi_req_t, logic, AXI request struct.
axi_rsp_t, logic, AXI response struct.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
slv_req_i  in  axi_req_t  request from upstream (meta buffer output)
slv_rsp_o  out  axi_rsp_t  response to upstream
mst_req_o  out  axi_req_t  request to endpoint
mst_rsp_i  in  axi_rsp_t  response from endpoint
rd_cnt_o  out  idx_width(MaxReadTxns+1)  outstanding read count
wr_cnt_o  out  idx_width(MaxWriteTxns+1)  outstanding write count (AW accepted, B not yet handshaked)
idle_o  out  1  all counters zero

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset: rd_cnt_q, wr_cnt_q and w_pend_q are 0. idle_o=1. rd_cnt_o=0, wr_cnt_o=0.
- Passthrough:
  - All payload fields pass combinationally; the block adds zero latency and no storage of payloads.
  - Only the valid/ready pairs on AR, AW and W are modified. R and B pass untouched.
- Handshake events, evaluated at the mst side:
  - ar_hs = mst_req_o.ar_valid & mst_rsp_i.ar_ready.
  - aw_hs = the same on AW.
  - w_last_hs = W handshake with w.last.
  - r_last_hs = R handshake with r.last.
  - b_hs = B handshake.
- Atomics:
  - is_atop = aw.atop[5:4] != ATOP_NONE.
  - atop_r = AtopSupport & is_atop & aw.atop[ATOP_R_RESP].
- Read counter: +1 on ar_hs, +1 on (aw_hs & atop_r), -1 on r_last_hs. ar_hs and an atop_r AW in the same cycle add 2. The net change is applied in one update.
- Write counter: +1 on aw_hs, -1 on b_hs.
- W pending counter (AWs accepted whose W burst is not finished): +1 on aw_hs, -1 on w_last_hs.
- Gating uses registered counts only. There is no combinational path from R/B handshakes to AR/AW ready.
  - ar_allow = rd_cnt_q < MaxReadTxns.
  - aw_allow = wr_cnt_q < MaxWriteTxns & (!atop_r | rd_cnt_q < MaxReadTxns).
  - If the AR and an atop_r AW both request and rd_cnt_q == MaxReadTxns-1, AR wins. The AW is stalled that cycle (aw_allow is evaluated with the AR's increment included).
  - mst_req_o.ar_valid = slv ar_valid & ar_allow; slv_rsp_o.ar_ready = mst ar_ready & ar_allow. AW is gated identically with aw_allow.
- W gating: w_allow = (w_pend_q != 0) | aw_hs. W may pass in the same cycle its AW is accepted. W valid and ready are both masked by w_allow.
- Boundary conditions:
  - Counter at max with a simultaneous decrement: the request is still blocked that cycle and is allowed the next cycle.
  - Simultaneous increment and decrement: the count is unchanged.
  - An AW already asserted by upstream stays stalled until allowed; AXI valid stability is preserved because gating is never based on ready.
- Assertions:
  - No decrement of any counter at 0.
  - No increment beyond its max.
  - w_pend_q <= wr_cnt_q.
  - Parameters >= 1.
- Outputs: idle_o = (rd_cnt_q==0) & (wr_cnt_q==0) & (w_pend_q==0). rd_cnt_o and wr_cnt_o are the registered counts.
- Reset mid-operation clears all counters immediately. In-flight responses after reset are a system error and are flagged by the underflow assertion.

Test Plan:
- MaxReadTxns=2: 3 back-to-back ARs, endpoint holds R -> ARs 1 and 2 accepted and the 3rd stalled (slv ar_ready=0), rd_cnt_o=2. On R last, the 3rd AR is accepted the next cycle and rd_cnt_o returns to 2.
- W presented 3 cycles before its AW -> W valid stays masked. W passes in the AW handshake cycle. After w.last, w_pend=0 and wr_cnt_o=1 until B, then idle_o=1.
- ATOP AtomicLoad (R response) with rd_cnt=MaxReadTxns -> AW stalled although wr_cnt=0. After one R last, the AW is accepted and both counters increment by 1.
- rd_cnt=1 with MaxReadTxns=2, AR and atop_r AW valid together -> AR accepted, AW stalled one cycle, rd_cnt ends at 2. The AW is then accepted only after an R last.
- Counter at max with a same-cycle B handshake and new AW -> AW not accepted that cycle, accepted the next, wr_cnt_o stays at MaxWriteTxns.
- Assert rst_ni low with 3 reads outstanding -> counters 0 asynchronously, idle_o=1, AR accepted the first cycle after reset release.

Source files
------------

// File: rtl/floo_axi_txn_limiter.sv
// Outstanding-transaction limiter for an AXI link: caps in-flight reads/writes,
// holds W beats until their AW is accepted, and reports occupancy.

package floo_axi_txn_limiter_pkg;

  typedef logic [3:0]  id_t;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;

  localparam logic [1:0]  ATOP_NONE   = 2'b00;
  localparam int unsigned ATOP_R_RESP = 5;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [5:0] atop;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } floo_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } floo_rsp_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

module floo_axi_txn_limiter #(
  parameter int unsigned MaxReadTxns  = 8,
  parameter int unsigned MaxWriteTxns = 8,
  parameter bit          AtopSupport  = 1'b1,
  parameter type         axi_req_t    = floo_axi_txn_limiter_pkg::floo_req_t,
  parameter type         axi_rsp_t    = floo_axi_txn_limiter_pkg::floo_rsp_t,
  localparam int unsigned RdCntW = floo_axi_txn_limiter_pkg::idx_width(MaxReadTxns + 1),
  localparam int unsigned WrCntW = floo_axi_txn_limiter_pkg::idx_width(MaxWriteTxns + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  axi_req_t          slv_req_i,
  output axi_rsp_t          slv_rsp_o,
  output axi_req_t          mst_req_o,
  input  axi_rsp_t          mst_rsp_i,
  output logic [RdCntW-1:0] rd_cnt_o,
  output logic [WrCntW-1:0] wr_cnt_o,
  output logic              idle_o
);

  import floo_axi_txn_limiter_pkg::ATOP_NONE;
  import floo_axi_txn_limiter_pkg::ATOP_R_RESP;

  logic [RdCntW-1:0] r_rd_cnt;
  logic [WrCntW-1:0] r_wr_cnt;
  logic [WrCntW-1:0] r_w_pend;

  logic w_atop_r;
  logic w_ar_allow, w_aw_allow, w_w_allow;
  logic w_ar_req, w_rd_room;
  logic w_ar_hs, w_aw_hs, w_w_last_hs, w_r_last_hs, w_b_hs;

  assign w_atop_r = AtopSupport
                  & (slv_req_i.aw.atop[5:4] != ATOP_NONE)
                  & slv_req_i.aw.atop[ATOP_R_RESP];

  assign w_ar_allow = (r_rd_cnt < RdCntW'(MaxReadTxns));
  assign w_ar_req   = slv_req_i.ar_valid & w_ar_allow;

  // A competing AR is charged first, so a read-returning atomic only passes if
  // there is still room after that AR. Gating never looks at ready signals.
  assign w_rd_room  = (({1'b0, r_rd_cnt} + (RdCntW + 1)'(w_ar_req))
                       < (RdCntW + 1)'(MaxReadTxns));
  assign w_aw_allow = (r_wr_cnt < WrCntW'(MaxWriteTxns)) & (~w_atop_r | w_rd_room);

  // Handshakes are rebuilt from the inputs rather than read back from mst_req_o,
  // which keeps the W gate free of a combinational loop through the output.
  assign w_ar_hs     = w_ar_req & mst_rsp_i.ar_ready;
  assign w_aw_hs     = slv_req_i.aw_valid & w_aw_allow & mst_rsp_i.aw_ready;
  assign w_w_allow   = (r_w_pend != '0) | w_aw_hs;
  assign w_w_last_hs = slv_req_i.w_valid & w_w_allow & mst_rsp_i.w_ready & slv_req_i.w.last;
  assign w_r_last_hs = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;
  assign w_b_hs      = mst_rsp_i.b_valid & slv_req_i.b_ready;

  // NOTE: whole-struct defaults come first so every field has a value on every
  // path; only the gated valid/ready bits are overridden below, so no latches.
  always_comb begin
    mst_req_o          = slv_req_i;
    slv_rsp_o          = mst_rsp_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & w_ar_allow;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & w_ar_allow;
    mst_req_o.aw_valid = slv_req_i.aw_valid & w_aw_allow;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & w_aw_allow;
    mst_req_o.w_valid  = slv_req_i.w_valid & w_w_allow;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready & w_w_allow;
  end

  // NOTE: non-blocking assignments for all state so every counter samples the
  // same pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_w_pend <= '0;
    end else begin
      r_rd_cnt <= r_rd_cnt + RdCntW'(w_ar_hs) + RdCntW'(w_aw_hs & w_atop_r)
                - RdCntW'(w_r_last_hs);
      r_wr_cnt <= r_wr_cnt + WrCntW'(w_aw_hs) - WrCntW'(w_b_hs);
      r_w_pend <= r_w_pend + WrCntW'(w_aw_hs) - WrCntW'(w_w_last_hs);
    end
  end

  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;
  assign idle_o   = (r_rd_cnt == '0) & (r_wr_cnt == '0) & (r_w_pend == '0);

  // Responses arriving after a mid-operation reset land here as underflows.
  a_params: assert property (@(posedge clk_i) (MaxReadTxns >= 1) && (MaxWriteTxns >= 1));
  a_rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_r_last_hs |-> (r_rd_cnt != '0));
  a_wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_b_hs |-> (r_wr_cnt != '0));
  a_wp_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_w_last_hs && !w_aw_hs) |-> (r_w_pend != '0));
  a_rd_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((RdCntW + 2)'(r_rd_cnt) + (RdCntW + 2)'(w_ar_hs) + (RdCntW + 2)'(w_aw_hs & w_atop_r))
      <= (RdCntW + 2)'(MaxReadTxns));
  a_wr_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((WrCntW + 1)'(r_wr_cnt) + (WrCntW + 1)'(w_aw_hs)) <= (WrCntW + 1)'(MaxWriteTxns));
  a_wp_le_wr: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_w_pend <= r_wr_cnt);

endmodule

// File: tb/tb_floo_axi_txn_limiter.sv
// Scoreboarded bench for floo_axi_txn_limiter: payloads are queued when driven
// and compared on handshake; occupancy and gating are checked cycle by cycle.

module tb_floo_axi_txn_limiter;

  import floo_axi_txn_limiter_pkg::*;

  localparam int unsigned MaxRd  = 3;
  localparam int unsigned MaxWr  = 2;
  localparam int unsigned RdCntW = idx_width(MaxRd + 1);
  localparam int unsigned WrCntW = idx_width(MaxWr + 1);

  logic              clk_i;
  logic              rst_ni;
  floo_req_t         slv_req;
  floo_rsp_t         slv_rsp;
  floo_req_t         mst_req;
  floo_rsp_t         mst_rsp;
  logic [RdCntW-1:0] rd_cnt;
  logic [WrCntW-1:0] wr_cnt;
  logic              idle;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_ar[$];
  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];
  logic [31:0] exp_r[$];
  logic [31:0] exp_b[$];

  floo_axi_txn_limiter #(
    .MaxReadTxns (MaxRd),
    .MaxWriteTxns(MaxWr),
    .AtopSupport (1'b1),
    .axi_req_t   (floo_req_t),
    .axi_rsp_t   (floo_rsp_t)
  ) u_dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .slv_req_i(slv_req),
    .slv_rsp_o(slv_rsp),
    .mst_req_o(mst_req),
    .mst_rsp_i(mst_rsp),
    .rd_cnt_o (rd_cnt),
    .wr_cnt_o (wr_cnt),
    .idle_o   (idle)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scores every handshake that happens in the current cycle, then moves on to
  // the next falling edge where new stimulus is driven.
  task automatic cyc();
    #1;
    if (mst_req.ar_valid && mst_rsp.ar_ready) begin
      if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
      else check("ar_addr", mst_req.ar.addr, exp_ar.pop_front());
    end
    if (mst_req.aw_valid && mst_rsp.aw_ready) begin
      if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
      else check("aw_addr", mst_req.aw.addr, exp_aw.pop_front());
    end
    if (mst_req.w_valid && mst_rsp.w_ready) begin
      if (exp_w.size() == 0) check("w_unexpected", 1, 0);
      else check("w_data", mst_req.w.data, exp_w.pop_front());
    end
    if (slv_rsp.r_valid && slv_req.r_ready) begin
      if (exp_r.size() == 0) check("r_unexpected", 1, 0);
      else check("r_data", slv_rsp.r.data, exp_r.pop_front());
    end
    if (slv_rsp.b_valid && slv_req.b_ready) begin
      if (exp_b.size() == 0) check("b_unexpected", 1, 0);
      else check("b_id", 32'(slv_rsp.b.id), exp_b.pop_front());
    end
    @(negedge clk_i);
  endtask

  task automatic ar_push(input logic [31:0] a);
    slv_req.ar_valid = 1'b1;
    slv_req.ar.addr  = a;
    exp_ar.push_back(a);
  endtask

  task automatic aw_push(input logic [31:0] a, input logic [5:0] atop);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = a;
    slv_req.aw.atop  = atop;
    exp_aw.push_back(a);
  endtask

  task automatic w_push(input logic [31:0] d);
    slv_req.w_valid = 1'b1;
    slv_req.w.data  = d;
    slv_req.w.last  = 1'b1;
    exp_w.push_back(d);
  endtask

  task automatic r_push(input logic [31:0] d);
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.data  = d;
    mst_rsp.r.last  = 1'b1;
    exp_r.push_back(d);
  endtask

  task automatic send_ar(input logic [31:0] a);
    ar_push(a);
    cyc();
    slv_req.ar_valid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d);
    w_push(d);
    cyc();
    slv_req.w_valid = 1'b0;
  endtask

  task automatic resp_r(input logic [31:0] d);
    r_push(d);
    cyc();
    mst_rsp.r_valid = 1'b0;
  endtask

  task automatic resp_b(input logic [3:0] id);
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = id;
    exp_b.push_back(32'(id));
    cyc();
    mst_rsp.b_valid = 1'b0;
  endtask

  initial begin
    rst_ni           = 1'b0;
    slv_req          = '0;
    mst_rsp          = '0;
    slv_req.r_ready  = 1'b1;
    slv_req.b_ready  = 1'b1;
    mst_rsp.ar_ready = 1'b1;
    mst_rsp.aw_ready = 1'b1;
    mst_rsp.w_ready  = 1'b1;

    // Reset state
    #1;
    check("rst_rd_cnt", 32'(rd_cnt), 0);
    check("rst_wr_cnt", 32'(wr_cnt), 0);
    check("rst_idle", 32'(idle), 1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Back-to-back ARs beyond the read limit while the endpoint holds R
    for (int i = 0; i < 3; i++) begin
      ar_push(32'h100 + 32'(i));
      #1;
      check("ar_rdy_room", 32'(slv_rsp.ar_ready), 1);
      cyc();
    end
    ar_push(32'h103);
    #1;
    check("ar_rdy_full", 32'(slv_rsp.ar_ready), 0);
    check("ar_mst_valid_full", 32'(mst_req.ar_valid), 0);
    check("rd_cnt_full", 32'(rd_cnt), 3);
    cyc();
    check("ar_stall_hold", 32'(slv_rsp.ar_ready), 0);
    r_push(32'hA0);
    #1;
    check("ar_blocked_on_dec", 32'(slv_rsp.ar_ready), 0);
    cyc();
    mst_rsp.r_valid = 1'b0;
    check("rd_cnt_dec", 32'(rd_cnt), 2);
    #1;
    check("ar_after_dec", 32'(slv_rsp.ar_ready), 1);
    cyc();
    slv_req.ar_valid = 1'b0;
    check("rd_cnt_refill", 32'(rd_cnt), 3);
    for (int i = 0; i < 3; i++) resp_r(32'hA1 + 32'(i));
    check("rd_drain_idle", 32'(idle), 1);

    // W presented ahead of its AW
    w_push(32'hD0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("w_masked", 32'(mst_req.w_valid), 0);
      check("w_rdy_masked", 32'(slv_rsp.w_ready), 0);
      cyc();
    end
    aw_push(32'h200, 6'b000000);
    #1;
    check("w_with_aw", 32'(mst_req.w_valid), 1);
    check("aw_rdy_plain", 32'(slv_rsp.aw_ready), 1);
    cyc();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    check("wr_cnt_after_aw", 32'(wr_cnt), 1);
    check("not_idle_wait_b", 32'(idle), 0);
    slv_req.w_valid = 1'b1;
    slv_req.w.data  = 32'hEE;
    #1;
    check("w_masked_no_pend", 32'(mst_req.w_valid), 0);
    cyc();
    slv_req.w_valid = 1'b0;
    resp_b(4'h3);
    check("wr_cnt_after_b", 32'(wr_cnt), 0);
    check("idle_after_b", 32'(idle), 1);

    // AtomicLoad while the read counter is full
    for (int i = 0; i < 3; i++) send_ar(32'h310 + 32'(i));
    check("rd_cnt_full_atop", 32'(rd_cnt), 3);
    aw_push(32'h300, 6'b100000);
    #1;
    check("atop_stall", 32'(slv_rsp.aw_ready), 0);
    check("atop_stall_wr0", 32'(wr_cnt), 0);
    cyc();
    r_push(32'hB0);
    #1;
    check("atop_stall_on_dec", 32'(slv_rsp.aw_ready), 0);
    cyc();
    mst_rsp.r_valid = 1'b0;
    #1;
    check("atop_allowed", 32'(slv_rsp.aw_ready), 1);
    cyc();
    slv_req.aw_valid = 1'b0;
    check("atop_rd_cnt", 32'(rd_cnt), 3);
    check("atop_wr_cnt", 32'(wr_cnt), 1);
    send_w(32'hD3);
    for (int i = 0; i < 3; i++) resp_r(32'hB1 + 32'(i));
    resp_b(4'h5);
    check("atop_idle", 32'(idle), 1);

    // AR and read-returning atomic race for the last read slot
    for (int i = 0; i < 2; i++) send_ar(32'h420 + 32'(i));
    ar_push(32'h410);
    aw_push(32'h400, 6'b110000);
    #1;
    check("race_ar_wins", 32'(slv_rsp.ar_ready), 1);
    check("race_aw_stall", 32'(slv_rsp.aw_ready), 0);
    cyc();
    slv_req.ar_valid = 1'b0;
    check("race_rd_cnt", 32'(rd_cnt), 3);
    #1;
    check("race_aw_still", 32'(slv_rsp.aw_ready), 0);
    cyc();
    r_push(32'hC0);
    #1;
    check("race_aw_on_dec", 32'(slv_rsp.aw_ready), 0);
    cyc();
    mst_rsp.r_valid = 1'b0;
    #1;
    check("race_aw_allowed", 32'(slv_rsp.aw_ready), 1);
    cyc();
    slv_req.aw_valid = 1'b0;
    check("race_rd_end", 32'(rd_cnt), 3);
    check("race_wr_end", 32'(wr_cnt), 1);
    send_w(32'hD4);
    for (int i = 0; i < 3; i++) resp_r(32'hC1 + 32'(i));
    resp_b(4'h6);
    check("race_idle", 32'(idle), 1);

    // Write counter at max with a same-cycle B and new AW
    aw_push(32'h500, 6'b000000);
    w_push(32'hD5);
    cyc();
    aw_push(32'h501, 6'b000000);
    w_push(32'hD6);
    cyc();
    slv_req.w_valid = 1'b0;
    check("wr_cnt_max", 32'(wr_cnt), 2);
    aw_push(32'h502, 6'b000000);
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 4'h1;
    exp_b.push_back(32'h1);
    #1;
    check("aw_blocked_on_b", 32'(slv_rsp.aw_ready), 0);
    cyc();
    mst_rsp.b_valid = 1'b0;
    check("wr_cnt_after_b_dec", 32'(wr_cnt), 1);
    w_push(32'hD7);
    #1;
    check("aw_after_b", 32'(slv_rsp.aw_ready), 1);
    cyc();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    check("wr_cnt_back_max", 32'(wr_cnt), 2);
    resp_b(4'h2);
    resp_b(4'h4);
    check("wr_idle", 32'(idle), 1);

    // Asynchronous reset with reads outstanding
    for (int i = 0; i < 3; i++) send_ar(32'h610 + 32'(i));
    check("pre_rst_rd_cnt", 32'(rd_cnt), 3);
    rst_ni = 1'b0;
    #1;
    check("async_rst_rd_cnt", 32'(rd_cnt), 0);
    check("async_rst_idle", 32'(idle), 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    ar_push(32'h600);
    #1;
    check("post_rst_ar_rdy", 32'(slv_rsp.ar_ready), 1);
    cyc();
    slv_req.ar_valid = 1'b0;
    check("post_rst_rd_cnt", 32'(rd_cnt), 1);
    resp_r(32'hE0);
    check("final_idle", 32'(idle), 1);

    check("sb_drain", 32'(exp_ar.size() + exp_aw.size() + exp_w.size()
                          + exp_r.size() + exp_b.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
